// File: rtl/uart_transmit_if.sv
// Byte-stream handshake into the UART transmitter.
// A transfer happens on a rising edge where tx_valid and tx_ready are both high.
interface uart_transmit_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames go out back to back.
// Latency: a push into an empty idle FIFO drives the start bit one cycle later.
// Backpressure: tx_ready drops while the FIFO is full, and pushes are ignored.
module uart_transmit #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  uart_transmit_if.slave                    s_if,
  output logic                              Tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FC_W-1:0]  FULL_CNT = FC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic               push, pop, bit_done, fifo_nonempty;
  logic [7:0]         head;

  assign fifo_nonempty = (count_q != '0);
  assign s_if.tx_ready = (count_q != FULL_CNT);
  assign push          = s_if.tx_valid && s_if.tx_ready;
  assign bit_done      = (bit_cnt_q == BIT_LAST);
  assign head          = mem_q[rd_ptr_q];
  assign Tx            = tx_q;
  assign fifo_count    = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_nonempty) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_done) state_d = fifo_nonempty ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The head is popped only when the shift register loads it.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = fifo_nonempty;
      STOP:    pop = bit_done && fifo_nonempty;
      default: pop = 1'b0;
    endcase
    busy = (state_q != IDLE) || fifo_nonempty;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_if.tx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_done ? '0 : bit_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        if (pop) begin
          shift_d = head;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            // Shift right so the next data bit always sits at shift[1].
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          tx_d = 1'b1;
          if (pop) begin
            shift_d = head;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end
endmodule
